// File: rtl/ahbl_apb3_bridge_multi_if.sv
// AHB-Lite slave side and APB3 master side of the bridge, bundled.
// "slave" is the bridge's view; "master" is the surrounding bus/fabric view.
interface ahbl_apb3_bridge_multi_if #(
  parameter int APB_SLOTS   = 16,
  parameter int PADDR_WIDTH = 32
);
  logic                   HSEL;
  logic [31:0]            HADDR;
  logic                   HWRITE;
  logic [1:0]             HTRANS;
  logic [2:0]             HSIZE;
  logic [31:0]            HWDATA;
  logic                   HREADYIN;
  logic                   HREADYOUT;
  logic [31:0]            HRDATA;
  logic                   HRESP;
  logic [APB_SLOTS-1:0]   PSEL;
  logic [PADDR_WIDTH-1:0] PADDR;
  logic                   PWRITE;
  logic                   PENABLE;
  logic [31:0]            PWDATA;
  logic [31:0]            PRDATA;
  logic                   PREADY;
  logic                   PSLVERR;
  logic                   TMO_PULSE;

  modport slave (
    input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HWDATA, HREADYIN,
    output HREADYOUT, HRDATA, HRESP,
    output PSEL, PADDR, PWRITE, PENABLE, PWDATA,
    input  PRDATA, PREADY, PSLVERR,
    output TMO_PULSE
  );

  modport master (
    output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HWDATA, HREADYIN,
    input  HREADYOUT, HRDATA, HRESP,
    input  PSEL, PADDR, PWRITE, PENABLE, PWDATA,
    output PRDATA, PREADY, PSLVERR,
    input  TMO_PULSE
  );
endinterface

// File: rtl/ahbl_apb3_bridge_multi.sv
// AHB-Lite to APB3 bridge with configurable slot decode, PADDR width and
// optional PREADY timeout. Every output is registered from the next state.
module ahbl_apb3_bridge_multi #(
  parameter int APB_SLOTS   = 16,
  parameter int SLOT_SHIFT  = 8,
  parameter int PADDR_WIDTH = 32,
  parameter int TIMEOUT     = 0
) (
  input logic                      HCLK,
  input logic                      HRESET,
  ahbl_apb3_bridge_multi_if.slave  bus
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2} state_t;

  state_t               state, state_nxt;
  logic [3:0]           slot_q;
  logic [3:0]           slot_in;
  logic [CNT_W-1:0]     cnt;
  logic [APB_SLOTS-1:0] sel_onehot;
  logic                 accept, in_range, tmo_fire, done_ok;
  logic                 unused_bits;

  assign slot_in    = bus.HADDR[SLOT_SHIFT+3:SLOT_SHIFT];
  assign accept     = bus.HSEL & bus.HREADYIN & bus.HTRANS[1];
  assign in_range   = {1'b0, slot_in} < 5'(APB_SLOTS);
  assign sel_onehot = APB_SLOTS'(1) << slot_q;
  // Size is fixed at 32 bits and SEQ/NONSEQ are treated alike.
  assign unused_bits = ^{bus.HSIZE, bus.HTRANS[0], bus.HADDR};

  always_comb begin
    state_nxt = state;
    tmo_fire  = 1'b0;
    done_ok   = 1'b0;
    case (state)
      IDLE:   if (accept) state_nxt = in_range ? LATCH : ERR1;
      LATCH:  state_nxt = SETUP;
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (bus.PREADY) begin
          if (bus.PSLVERR) state_nxt = ERR1;
          else begin
            state_nxt = IDLE;
            done_ok   = 1'b1;
          end
        end else if (TIMEOUT > 0 && cnt == CNT_W'(TIMEOUT - 1)) begin
          // This stalled cycle is the TIMEOUT-th one; abandon the access.
          state_nxt = ERR1;
          tmo_fire  = 1'b1;
        end
      end
      ERR1:    state_nxt = ERR2;
      ERR2:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state         <= IDLE;
      cnt           <= '0;
      slot_q        <= '0;
      bus.HREADYOUT <= 1'b1;
      bus.HRESP     <= 1'b0;
      bus.HRDATA    <= '0;
      bus.PSEL      <= '0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PADDR     <= '0;
      bus.PWDATA    <= '0;
      bus.TMO_PULSE <= 1'b0;
    end else begin
      state         <= state_nxt;
      bus.HREADYOUT <= (state_nxt == IDLE) || (state_nxt == ERR2);
      bus.HRESP     <= (state_nxt == ERR1) || (state_nxt == ERR2);
      bus.PENABLE   <= (state_nxt == ACCESS);
      bus.PSEL      <= (state_nxt == SETUP || state_nxt == ACCESS) ? sel_onehot : '0;
      bus.TMO_PULSE <= tmo_fire;
      if (state == IDLE && accept) begin
        slot_q     <= slot_in;
        bus.PADDR  <= bus.HADDR[PADDR_WIDTH-1:0];
        bus.PWRITE <= bus.HWRITE;
      end
      // HWDATA belongs to the AHB data phase, i.e. the cycle after acceptance.
      if (state == LATCH) bus.PWDATA <= bus.HWDATA;
      if (done_ok && !bus.PWRITE) bus.HRDATA <= bus.PRDATA;
      if (state_nxt == SETUP) cnt <= '0;
      else if (TIMEOUT > 0 && state == ACCESS && !bus.PREADY) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ahbl_apb3_bridge_multi.sv
// Bench for ahbl_apb3_bridge_multi: vector table, directed corner sequences
// and random transfers scored against a transfer-level timing model.
module tb_ahbl_apb3_bridge_multi;
  localparam int SLOTS = 4;
  localparam int PAW   = 16;
  localparam int TMO   = 5;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  ahbl_apb3_bridge_multi_if #(.APB_SLOTS(SLOTS), .PADDR_WIDTH(PAW)) bus();

  ahbl_apb3_bridge_multi #(
    .APB_SLOTS(SLOTS), .SLOT_SHIFT(8), .PADDR_WIDTH(PAW), .TIMEOUT(TMO)
  ) dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus));

  // What one transfer looked like, cycle 0 being the address phase.
  typedef struct {
    int end_cyc, low, hresp, pen, tmo, psel_cnt, first_psel, first_pen, first_tmo;
    logic [SLOTS-1:0] psel;
    logic [PAW-1:0]   paddr;
    logic             pwrite;
    logic [31:0]      pwdata, hrdata;
  } obs_t;

  typedef struct {
    logic [31:0] addr; logic wr; logic [31:0] wd; int w; bit err; logic [31:0] rd;
    int e_end; logic [SLOTS-1:0] e_psel; int e_pen; int e_low; int e_hresp; int e_tmo;
    logic [31:0] e_hrdata; logic [PAW-1:0] e_paddr;
  } vec_t;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HADDR = '0;
    bus.HWDATA = '0; bus.HSIZE = 3'b010; bus.HREADYIN = 1'b1;
    bus.PRDATA = '0; bus.PREADY = 1'b1; bus.PSLVERR = 1'b0;
  endtask

  // Drives one transfer; the APB slave holds PREADY low for w ACCESS cycles.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input int w, input bit err, input logic [31:0] rd, input bit b2b,
                      output obs_t o);
    o = '{default: 0};
    o.end_cyc = -1; o.first_psel = -1; o.first_pen = -1; o.first_tmo = -1;
    if (!b2b) begin
      @(posedge HCLK); #1;
    end
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = addr; bus.HWRITE = wr;
    bus.HREADYIN = 1'b1; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge HCLK); #1;
      bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HADDR = $urandom; bus.HWRITE = 1'($urandom);
      bus.HWDATA  = (c == 1) ? wd : $urandom;
      bus.PREADY  = (c >= 3 + w);
      bus.PSLVERR = err && (c >= 3 + w);
      bus.PRDATA  = (c >= 3 + w) ? rd : $urandom;
      @(negedge HCLK);
      if (bus.PSEL != '0) begin
        if (o.first_psel < 0) begin
          o.first_psel = c; o.paddr = bus.PADDR; o.pwrite = bus.PWRITE;
        end
        o.psel |= bus.PSEL;
        o.psel_cnt++;
      end
      if (bus.PENABLE) begin
        if (o.first_pen < 0) begin
          o.first_pen = c; o.pwdata = bus.PWDATA;
        end
        o.pen++;
      end
      if (!bus.HREADYOUT) o.low++;
      if (bus.HRESP) o.hresp++;
      if (bus.TMO_PULSE) begin
        if (o.first_tmo < 0) o.first_tmo = c;
        o.tmo++;
      end
      if (bus.HREADYOUT && !bus.HRESP) begin
        o.end_cyc = c; o.hrdata = bus.HRDATA;
        break;
      end
    end
  endtask

  // Expected transfer shape from the latency rules: 3 wait states plus one per
  // stalled cycle, two-cycle error tail, timeout after TMO stalled cycles.
  function automatic obs_t model(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                                 input int w, input bit err, input logic [31:0] rd,
                                 input logic [31:0] prev);
    obs_t m;
    int slot;
    m = '{default: 0};
    m.first_psel = -1; m.first_pen = -1; m.first_tmo = -1; m.hrdata = prev;
    slot = int'(a[11:8]);
    if (slot >= SLOTS) begin
      m.end_cyc = 3; m.low = 1; m.hresp = 2;
      return m;
    end
    m.first_psel = 2; m.first_pen = 3; m.psel[slot] = 1'b1;
    m.paddr = a[PAW-1:0]; m.pwrite = wr; m.pwdata = wd;
    if (w >= TMO) begin
      m.pen = TMO; m.first_tmo = 3 + TMO; m.tmo = 1;
      m.end_cyc = m.first_tmo + 2; m.low = m.first_tmo; m.hresp = 2;
    end else if (err) begin
      m.pen = w + 1; m.end_cyc = w + 6; m.low = w + 4; m.hresp = 2;
    end else begin
      m.pen = w + 1; m.end_cyc = w + 4; m.low = w + 3;
      if (!wr) m.hrdata = rd;
    end
    m.psel_cnt = m.pen + 1;
    return m;
  endfunction

  task automatic cmp_obs(input string nm, input obs_t o, input obs_t m);
    check({nm, ".end"}, o.end_cyc, m.end_cyc);
    check({nm, ".low"}, o.low, m.low);
    check({nm, ".hresp"}, o.hresp, m.hresp);
    check({nm, ".pen"}, o.pen, m.pen);
    check({nm, ".tmo"}, o.tmo, m.tmo);
    check({nm, ".psel"}, 32'(o.psel), 32'(m.psel));
    check({nm, ".psel_cnt"}, o.psel_cnt, m.psel_cnt);
    check({nm, ".hrdata"}, o.hrdata, m.hrdata);
    if (m.first_psel >= 0) begin
      check({nm, ".psel_cyc"}, o.first_psel, m.first_psel);
      check({nm, ".pen_cyc"}, o.first_pen, m.first_pen);
      check({nm, ".paddr"}, 32'(o.paddr), 32'(m.paddr));
      check({nm, ".pwrite"}, 32'(o.pwrite), 32'(m.pwrite));
      check({nm, ".pwdata"}, o.pwdata, m.pwdata);
    end
    if (m.tmo > 0) check({nm, ".tmo_cyc"}, o.first_tmo, m.first_tmo);
  endtask

  vec_t tbl[11];

  initial begin
    obs_t o, e;
    logic [31:0] prev, a, wd, rd;
    int w;
    bit err, b2b;
    logic wr;

    tbl[0]  = '{32'h0000_0304, 1'b1, 32'hDEAD_BEEF, 0,  1'b0, 32'h0,
                4,  4'b1000, 1, 3, 0, 0, 32'h0,         16'h0304};
    tbl[1]  = '{32'h0000_0010, 1'b0, 32'h1111_1111, 2,  1'b0, 32'h1234_5678,
                6,  4'b0001, 3, 5, 0, 0, 32'h1234_5678, 16'h0010};
    tbl[2]  = '{32'h0000_0220, 1'b0, 32'h2222_2222, 0,  1'b1, 32'hCAFE_F00D,
                6,  4'b0100, 1, 4, 2, 0, 32'h1234_5678, 16'h0220};
    tbl[3]  = '{32'h0000_0900, 1'b0, 32'h3333_3333, 0,  1'b0, 32'h0BAD_F00D,
                3,  4'b0000, 0, 1, 2, 0, 32'h1234_5678, 16'h0000};
    tbl[4]  = '{32'h0000_0108, 1'b1, 32'h4444_4444, 99, 1'b0, 32'h0,
                10, 4'b0010, 5, 8, 2, 1, 32'h1234_5678, 16'h0108};
    tbl[5]  = '{32'h0000_0104, 1'b0, 32'h5555_5555, 1,  1'b0, 32'h0BAD_CAFE,
                5,  4'b0010, 2, 4, 0, 0, 32'h0BAD_CAFE, 16'h0104};
    tbl[6]  = '{32'h0000_0330, 1'b0, 32'h6666_6666, 4,  1'b0, 32'hA5A5_A5A5,
                8,  4'b1000, 5, 7, 0, 0, 32'hA5A5_A5A5, 16'h0330};
    tbl[7]  = '{32'h0000_0040, 1'b0, 32'h7777_7777, 5,  1'b0, 32'h5A5A_5A5A,
                10, 4'b0001, 5, 8, 2, 1, 32'hA5A5_A5A5, 16'h0040};
    tbl[8]  = '{32'hABCD_0354, 1'b1, 32'h8888_8888, 0,  1'b0, 32'h0,
                4,  4'b1000, 1, 3, 0, 0, 32'hA5A5_A5A5, 16'h0354};
    tbl[9]  = '{32'h0000_0C00, 1'b1, 32'h9999_9999, 0,  1'b1, 32'h0,
                3,  4'b0000, 0, 1, 2, 0, 32'hA5A5_A5A5, 16'h0000};
    tbl[10] = '{32'h0000_0100, 1'b0, 32'hAAAA_AAAA, 3,  1'b1, 32'hFFFF_0000,
                9,  4'b0010, 4, 7, 2, 0, 32'hA5A5_A5A5, 16'h0100};

    idle_bus();
    HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    check("rst.hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check("rst.hresp", 32'(bus.HRESP), 32'd0);
    check("rst.psel", 32'(bus.PSEL), 32'd0);
    check("rst.penable", 32'(bus.PENABLE), 32'd0);
    check("rst.pwrite", 32'(bus.PWRITE), 32'd0);
    check("rst.paddr", 32'(bus.PADDR), 32'd0);
    check("rst.pwdata", bus.PWDATA, 32'd0);
    check("rst.hrdata", bus.HRDATA, 32'd0);
    check("rst.tmo", 32'(bus.TMO_PULSE), 32'd0);

    for (int i = 0; i < 11; i++) begin
      xfer(tbl[i].addr, tbl[i].wr, tbl[i].wd, tbl[i].w, tbl[i].err, tbl[i].rd, 1'b0, o);
      e = '{default: 0};
      e.end_cyc = tbl[i].e_end; e.low = tbl[i].e_low; e.hresp = tbl[i].e_hresp;
      e.pen = tbl[i].e_pen; e.tmo = tbl[i].e_tmo; e.psel = tbl[i].e_psel;
      e.psel_cnt = (tbl[i].e_psel != '0) ? tbl[i].e_pen + 1 : 0;
      e.first_psel = (tbl[i].e_psel != '0) ? 2 : -1;
      e.first_pen = 3; e.first_tmo = (tbl[i].e_tmo != 0) ? 3 + TMO : -1;
      e.paddr = tbl[i].e_paddr; e.pwrite = tbl[i].wr; e.pwdata = tbl[i].wd;
      e.hrdata = tbl[i].e_hrdata;
      cmp_obs($sformatf("vec%0d", i), o, e);
    end

    // BUSY and HREADYIN=0 address phases must be ignored.
    @(posedge HCLK); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b01; bus.HADDR = 32'h0000_0100; bus.HWRITE = 1'b1;
    @(posedge HCLK); #1;
    bus.HTRANS = 2'b10; bus.HREADYIN = 1'b0;
    @(negedge HCLK);
    check("ign.busy.hready", 32'(bus.HREADYOUT), 32'd1);
    @(posedge HCLK); #1;
    idle_bus();
    for (int k = 0; k < 2; k++) begin
      @(negedge HCLK);
      check($sformatf("ign.hready%0d", k), 32'(bus.HREADYOUT), 32'd1);
      check($sformatf("ign.psel%0d", k), 32'(bus.PSEL), 32'd0);
    end

    // Reset while the slave is stalling in ACCESS.
    @(posedge HCLK); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h0000_0200; bus.HWRITE = 1'b0;
    bus.PREADY = 1'b0;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check("mid.penable", 32'(bus.PENABLE), 32'd1);
    check("mid.psel", 32'(bus.PSEL), 32'h4);
    @(posedge HCLK); #1 HRESET = 1'b1;
    @(posedge HCLK); #1 HRESET = 1'b0;
    @(negedge HCLK);
    check("mrst.psel", 32'(bus.PSEL), 32'd0);
    check("mrst.penable", 32'(bus.PENABLE), 32'd0);
    check("mrst.hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check("mrst.hresp", 32'(bus.HRESP), 32'd0);
    check("mrst.hrdata", bus.HRDATA, 32'd0);
    @(negedge HCLK);
    check("mrst.hresp_after", 32'(bus.HRESP), 32'd0);
    bus.PREADY = 1'b1;
    prev = 32'h0;

    // Back-to-back writes after reset.
    xfer(32'h0000_0114, 1'b1, 32'h0102_0304, 0, 1'b0, 32'h0, 1'b0, o);
    cmp_obs("b2b0", o, model(32'h0000_0114, 1'b1, 32'h0102_0304, 0, 1'b0, 32'h0, prev));
    xfer(32'h0000_0218, 1'b1, 32'hF0E0_D0C0, 1, 1'b0, 32'h0, 1'b1, o);
    cmp_obs("b2b1", o, model(32'h0000_0218, 1'b1, 32'hF0E0_D0C0, 1, 1'b0, 32'h0, prev));

    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      a[11:8] = 4'($urandom_range(0, 5));
      wr = 1'($urandom); wd = $urandom; rd = $urandom;
      w = $urandom_range(0, 6);
      err = ($urandom_range(0, 3) == 0);
      b2b = 1'($urandom);
      e = model(a, wr, wd, w, err, rd, prev);
      xfer(a, wr, wd, w, err, rd, b2b, o);
      cmp_obs($sformatf("rnd%0d", i), o, e);
      prev = e.hrdata;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
